// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// One-bit full adder, reused by the serial controller for every bit position.
// Purely combinational: no latency, no backpressure.
module fa_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: a_in + b_in + cin, LSB first, one shared full adder; optional ovf via SERIAL_ADD_OVF_EN.
// Latency: start accepted at edge k -> done pulse in the cycle after edge k+WIDTH.
// Backpressure: start is only taken in IDLE; while busy it is ignored.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             fa_s;
   logic             fa_cout;

   fa_bit u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         cnt   <= '0;
         carry <= 1'b0;
         a_sh  <= '0;
         b_sh  <= '0;
`ifdef SERIAL_ADD_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a_in;
                  b_sh  <= b_in;
                  carry <= cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               sum   <= {fa_s, sum[WIDTH-1:1]};
               carry <= fa_cout;
               if (cnt == LAST_BIT) begin
                  // Counter parks on the last bit instead of wrapping.
                  cout  <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                  ovf   <= carry ^ fa_cout;
`endif
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 against an arithmetic reference model.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a_in  (a_in),
      .b_in  (b_in),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: exact (W+1)-bit sum, and signed overflow from operand/result signs.
   function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      logic [W:0] r;
      r = ref_sum(a, b, c);
      return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
   endfunction

   // Presents one start pulse and waits (bounded) for done; lat counts the start cycle.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, output int lat);
      start = 1'b1; a_in = a; b_in = b; cin = c;
      tick();
      start = 1'b0;
      a_in = $urandom; b_in = $urandom; cin = $urandom;
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; a_in = 8'hAA; b_in = 8'h55; cin = 1'b1;
      tick(); tick();
      rst = 1'b0; start = 1'b0;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
         bad++;
         $display("FAIL reset: busy=%b done=%b sum=%h cout=%b expected all zero", busy, done, sum, cout);
      end
`ifdef SERIAL_ADD_OVF_EN
      total++;
      if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
   endtask

   task automatic test_vector(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int lat;
      logic [W:0] r;
      r = ref_sum(a, b, c);
      run_op(a, b, c, lat);
      total++;
      if (lat != W + 1) begin
         bad++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, W + 1);
      end
      total++;
      if (sum !== r[W-1:0] || cout !== r[W] || busy !== 1'b1) begin
         bad++;
         $display("FAIL %s_result: sum=%h cout=%b busy=%b expected sum=%h cout=%b busy=1", name, sum, cout, busy, r[W-1:0], r[W]);
      end
`ifdef SERIAL_ADD_OVF_EN
      total++;
      if (ovf !== ref_ovf(a, b, c)) begin
         bad++; $display("FAIL %s_ovf: got %b expected %b", name, ovf, ref_ovf(a, b, c));
      end
`endif
      // Result must hold through idle cycles and done must be a single pulse.
      tick(); tick(); tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || sum !== r[W-1:0] || cout !== r[W]) begin
         bad++;
         $display("FAIL %s_hold: done=%b busy=%b sum=%h cout=%b expected done=0 busy=0 sum=%h cout=%b", name, done, busy, sum, cout, r[W-1:0], r[W]);
      end
   endtask

   task automatic test_directed();
      test_vector("zero", 8'h00, 8'h00, 1'b0);
      test_vector("wrap", 8'hFF, 8'h01, 1'b0);
      test_vector("sovf", 8'h7F, 8'h00, 1'b1);
   endtask

   task automatic test_ignore_start();
      int lat;
      int dones;
      logic [W:0] r;
      r = ref_sum(8'h3C, 8'h21, 1'b0);
      start = 1'b1; a_in = 8'h3C; b_in = 8'h21; cin = 1'b0;
      tick();
      start = 1'b0;
      tick(); tick();
      start = 1'b1; a_in = 8'hF0; b_in = 8'h0F; cin = 1'b1;
      tick();
      start = 1'b0;
      lat = 4;
      while (done !== 1'b1 && lat < 40) begin tick(); lat++; end
      total++;
      if (lat != W + 1 || sum !== r[W-1:0] || cout !== r[W]) begin
         bad++;
         $display("FAIL ignore_start: lat=%0d sum=%h cout=%b expected lat=%0d sum=%h cout=%b", lat, sum, cout, W + 1, r[W-1:0], r[W]);
      end
      dones = 0;
      for (int i = 0; i < 2 * W; i++) begin
         tick();
         if (done === 1'b1) dones++;
      end
      total++;
      if (dones != 0 || busy !== 1'b0) begin
         bad++; $display("FAIL ignore_start_extra_done: got %0d pulses busy=%b expected 0 pulses busy=0", dones, busy);
      end
   endtask

   task automatic test_reset_mid();
      int dones;
      start = 1'b1; a_in = 8'h5A; b_in = 8'h66; cin = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (busy !== 1'b0 || sum !== '0 || done !== 1'b0 || cout !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid: busy=%b sum=%h done=%b cout=%b expected 0 00 0 0", busy, sum, done, cout);
      end
      dones = 0;
      for (int i = 0; i < W + 4; i++) begin
         tick();
         if (done === 1'b1) dones++;
      end
      total++;
      if (dones != 0) begin bad++; $display("FAIL reset_mid_done: got %0d pulses expected 0", dones); end
      test_vector("after_reset", 8'h19, 8'hC4, 1'b1);
   endtask

   task automatic test_back_to_back();
      int t1, t2, n;
      logic [W-1:0] s1, s2, s_between;
      t1 = -1; t2 = -1;
      start = 1'b1; a_in = 8'h12; b_in = 8'h34; cin = 1'b0;
      tick();
      a_in = 8'hA5; b_in = 8'h5A;
      n = 0;
      while (t1 < 0 && n < 40) begin
         tick(); n++;
         if (done === 1'b1) begin t1 = cyc; s1 = sum; end
      end
      tick();
      s_between = sum;
      tick();
      start = 1'b0;
      a_in = 8'h00; b_in = 8'h00;
      n = 0;
      while (t2 < 0 && n < 40) begin
         tick(); n++;
         if (done === 1'b1) begin t2 = cyc; s2 = sum; end
      end
      total++;
      if (t1 < 0 || t2 < 0 || t2 - t1 != W + 2) begin
         bad++; $display("FAIL b2b_period: t1=%0d t2=%0d expected spacing %0d", t1, t2, W + 2);
      end
      total++;
      if (s1 !== 8'h46 || s_between !== 8'h46 || s2 !== 8'hFF) begin
         bad++; $display("FAIL b2b_sums: got %h/%h/%h expected 46/46/ff", s1, s_between, s2);
      end
      tick(); tick();
   endtask

   task automatic test_fa_sweep();
      logic [2:0] v;
      logic [W:0] r;
      int lat;
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         r = ref_sum({7'd0, v[2]}, {7'd0, v[1]}, v[0]);
         run_op({7'd0, v[2]}, {7'd0, v[1]}, v[0], lat);
         total++;
         if (lat != W + 1 || sum !== r[W-1:0] || cout !== r[W]) begin
            bad++;
            $display("FAIL fa_sweep_%0d: lat=%0d sum=%h cout=%b expected lat=%0d sum=%h cout=%b", i, lat, sum, cout, W + 1, r[W-1:0], r[W]);
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b;
      logic c;
      logic [W:0] r;
      int lat;
      for (int i = 0; i < 25; i++) begin
         a = W'($urandom); b = W'($urandom); c = 1'($urandom);
         r = ref_sum(a, b, c);
         run_op(a, b, c, lat);
         total++;
         if (lat != W + 1 || sum !== r[W-1:0] || cout !== r[W]) begin
            bad++;
            $display("FAIL random_%0d: %h+%h+%b lat=%0d sum=%h cout=%b expected sum=%h cout=%b", i, a, b, c, lat, sum, cout, r[W-1:0], r[W]);
         end
`ifdef SERIAL_ADD_OVF_EN
         total++;
         if (ovf !== ref_ovf(a, b, c)) begin
            bad++; $display("FAIL random_ovf_%0d: got %b expected %b", i, ovf, ref_ovf(a, b, c));
         end
`endif
         tick();
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
      test_reset();
      test_directed();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_fa_sweep();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter: WIDTH, 8, operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port: start  input  1  request to add a_in + b_in + cin.
REQ-005 The block SHALL have port: a_in  input  WIDTH  operand A, sampled only on accepted start.
REQ-006 The block SHALL have port: b_in  input  WIDTH  operand B, sampled only on accepted start.
REQ-007 The block SHALL have port: cin  input  1  carry-in, sampled only on accepted start.
REQ-008 The block SHALL have port: busy  output  1  high while an addition is in progress.
REQ-009 The block SHALL have port: done  output  1  one-cycle pulse when the result is valid.
REQ-010 The block SHALL have port: sum  output  WIDTH  result, held stable from done until the next accepted start.
REQ-011 The block SHALL have port: cout  output  1  final carry-out, same validity as sum.

Function
REQ-012 The block SHALL compute the sum bit-serially, LSB first, using exactly one 1-bit full-adder instance shared across all bit positions.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE, start=1 SHALL load the operand shift registers and the carry register from cin, clear the bit counter, and move the FSM to RUN.
REQ-015 In RUN, each cycle SHALL process operand bit i, shift the sum bit into sum from the MSB end, register the carry, and increment the counter.
REQ-016 After the cycle that processes bit WIDTH-1, the FSM SHALL move to DONE.
REQ-017 In DONE, done=1 for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-018 Latency SHALL be fixed: start accepted at edge k gives done=1 during the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles start-to-done.
REQ-019 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-020 start SHALL be ignored in RUN and DONE, with no effect on operands or the result.
REQ-021 A start held high continuously SHALL be accepted in the first IDLE cycle after DONE, giving a back-to-back period of WIDTH+2 cycles.
REQ-022 sum and cout SHALL change only during RUN and SHALL be unchanged in IDLE.
REQ-023 The result SHALL equal (a_in + b_in + cin) mod 2^WIDTH, with cout equal to bit WIDTH of the exact sum.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap during RUN.

Reset
REQ-025 On rst=1 at a rising clk edge, the FSM SHALL enter IDLE and busy, done, sum, cout, the counter and the carry register SHALL all clear to 0.
REQ-026 rst SHALL take priority over start.
REQ-027 rst asserted mid-RUN SHALL abort the operation with no done pulse.

Configuration
REQ-028 With macro SERIAL_ADD_OVF_EN defined, the block SHALL add output port ovf  output  1  signed overflow, computed as (carry into MSB) XOR cout, with the same validity and reset value 0 as sum.
REQ-029 With SERIAL_ADD_OVF_EN undefined, the ovf port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 Package serial_add_pkg SHALL hold the FSM state enum (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-031 The 1-bit full adder SHALL be a separate sub-module fa_bit with ports (a, b, cin, s, cout) that implements s = a^b^cin and cout = ab | a·cin | b·cin.
REQ-032 The controller SHALL instantiate fa_bit exactly once.

Verification (WIDTH=8)
REQ-033 The bench SHALL apply 0x00 + 0x00, cin=0 -> done after 9 cycles, sum=0x00, cout=0, ovf=0.
REQ-034 The bench SHALL apply 0xFF + 0x01, cin=0 -> sum=0x00, cout=1, ovf=0; then 0x7F + 0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
REQ-035 The bench SHALL pulse start again 3 cycles into RUN with different operands -> the first result completes unchanged and no second done pulse occurs.
REQ-036 The bench SHALL assert rst at RUN cycle 4 -> the next cycle has busy=0, sum=0x00, and no done pulse; a new start then completes normally.
REQ-037 The bench SHALL hold start=1 over two operations, 0x12 + 0x34 then 0xA5 + 0x5A -> done pulses 10 cycles apart with sum=0x46 then 0xFF, and sum holds between the pulses.
REQ-038 The bench SHALL sweep all 8 combinations of operand bit 0 and cin using a=0x01/0x00, b=0x01/0x00 -> sum and cout match the full-adder truth table extended to 8 bits.
